// File: rtl/lmsm_sequencer.sv
// Expands a decoded load-multiple / store-multiple into one single-register
// memory micro-op per cycle, holding fetch/decode stalled until the last issues.
module lmsm_sequencer #(
  parameter int DATA_W    = 16,
  parameter int NREGS     = 8,
  parameter int ADDR_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     is_lm_i,
  input  logic [NREGS-1:0]         reg_list_i,
  input  logic [DATA_W-1:0]        base_addr_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     stall_o,
  output logic                     uop_valid_o,
  output logic                     uop_is_load_o,
  output logic [$clog2(NREGS)-1:0] uop_reg_o,
  output logic [DATA_W-1:0]        uop_addr_o,
  output logic                     uop_regwrite_o,
  output logic                     uop_last_o
);

  localparam int REG_W = $clog2(NREGS);

  // Handshake: a micro-op is offered while uop_valid_o=1 and is consumed on
  // the rising edge where hold_i=0; while hold_i=1 the same micro-op is re-offered.

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              lm_q, lm_d;

  logic [REG_W-1:0]  low_idx;
  logic [NREGS-1:0]  list_rest;
  logic              last;
  logic              in_issue;
  logic              accept;

  assign in_issue  = (state_q == ISSUE);
  // Clearing the lowest set bit leaves the registers still to be issued.
  assign list_rest = list_q & (list_q - NREGS'(1));
  assign last      = (list_q != '0) && (list_rest == '0);
  assign accept    = start_i && !flush_i && (reg_list_i != '0);

  always_comb begin
    low_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list_q[i]) low_idx = REG_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      lm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      lm_q    <= lm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    lm_d    = lm_q;
    if (flush_i) begin
      state_d = IDLE;
      list_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = ISSUE;
            list_d  = reg_list_i;
            addr_d  = base_addr_i;
            lm_d    = is_lm_i;
          end
        end
        ISSUE: begin
          if (!hold_i) begin
            list_d = list_rest;
            addr_d = addr_q + DATA_W'(ADDR_STEP);
            if (last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Micro-op fields are gated by ISSUE so that stale registers never leak out.
  always_comb begin
    busy_o         = in_issue;
    uop_valid_o    = in_issue;
    uop_is_load_o  = in_issue && lm_q;
    uop_reg_o      = in_issue ? low_idx : '0;
    uop_addr_o     = in_issue ? addr_q : '0;
    uop_regwrite_o = in_issue && lm_q;
    uop_last_o     = in_issue && last;
    // Dropping stall on the final consumed micro-op lets decode advance bubble-free.
    if (in_issue) stall_o = !(last && !hold_i);
    else          stall_o = accept;
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: each cycle drives inputs at the falling
// edge and compares the full output bundle against hand-computed values.
module tb_lmsm_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        is_lm_i;
  logic [7:0]  reg_list_i;
  logic [15:0] base_addr_i;
  logic        hold_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_o;
  logic        uop_valid_o;
  logic        uop_is_load_o;
  logic [2:0]  uop_reg_o;
  logic [15:0] uop_addr_o;
  logic        uop_regwrite_o;
  logic        uop_last_o;

  int checks   = 0;
  int failures = 0;

  lmsm_sequencer #(.DATA_W(16), .NREGS(8), .ADDR_STEP(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .is_lm_i        (is_lm_i),
    .reg_list_i     (reg_list_i),
    .base_addr_i    (base_addr_i),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .stall_o        (stall_o),
    .uop_valid_o    (uop_valid_o),
    .uop_is_load_o  (uop_is_load_o),
    .uop_reg_o      (uop_reg_o),
    .uop_addr_o     (uop_addr_o),
    .uop_regwrite_o (uop_regwrite_o),
    .uop_last_o     (uop_last_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle layout: {busy, stall, valid, load, regwrite, last, reg[2:0], addr[15:0]}
  function automatic logic [24:0] ex(input logic busy, input logic stall,
                                     input logic valid, input logic load,
                                     input logic rw, input logic last,
                                     input logic [2:0] r, input logic [15:0] a);
    return {busy, stall, valid, load, rw, last, r, a};
  endfunction

  function automatic logic [24:0] observed();
    return {busy_o, stall_o, uop_valid_o, uop_is_load_o, uop_regwrite_o,
            uop_last_o, uop_reg_o, uop_addr_o};
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%07h exp=%07h", tag, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs at the falling edge, settle, then caller checks
  task automatic cyc(input logic st, input logic lm, input logic [7:0] lst,
                     input logic [15:0] base, input logic hold, input logic flush);
    @(negedge clk);
    start_i     = st;
    is_lm_i     = lm;
    reg_list_i  = lst;
    base_addr_i = base;
    hold_i      = hold;
    flush_i     = flush;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
  endtask

  localparam logic [24:0] ZERO = 25'h0;

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0; is_lm_i = 1'b0; reg_list_i = '0; base_addr_i = '0;
    hold_i = 1'b0; flush_i = 1'b0;

    // reset state
    idle_cyc();
    check("reset_asserted", observed(), ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc();
    check("reset_released", observed(), ZERO);

    // SM 0010_0101 @0040
    cyc(1'b1, 1'b0, 8'b0010_0101, 16'h0040, 1'b0, 1'b0);
    check("sm_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    idle_cyc(); check("sm_r0", observed(), ex(1,1,1,0,0,0,3'd0,16'h0040));
    idle_cyc(); check("sm_r2", observed(), ex(1,1,1,0,0,0,3'd2,16'h0041));
    idle_cyc(); check("sm_r5", observed(), ex(1,0,1,0,0,1,3'd5,16'h0042));
    idle_cyc(); check("sm_done", observed(), ZERO);

    // LM FF @FFFE, address wraps
    cyc(1'b1, 1'b1, 8'hFF, 16'hFFFE, 1'b0, 1'b0);
    check("lm8_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = 16'(16'hFFFE + i);
      idle_cyc();
      check($sformatf("lm8_r%0d", i), observed(),
            ex(1, i != 7, 1, 1, 1, i == 7, 3'(i), a));
    end
    idle_cyc(); check("lm8_done", observed(), ZERO);

    // LM 1000_0001 with two hold cycles on the first micro-op
    cyc(1'b1, 1'b1, 8'b1000_0001, 16'h1234, 1'b0, 1'b0);
    check("hold_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    check("hold_r0_a", observed(), ex(1,1,1,1,1,0,3'd0,16'h1234));
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    check("hold_r0_b", observed(), ex(1,1,1,1,1,0,3'd0,16'h1234));
    idle_cyc(); check("hold_r0_c", observed(), ex(1,1,1,1,1,0,3'd0,16'h1234));
    idle_cyc(); check("hold_r7", observed(), ex(1,0,1,1,1,1,3'd7,16'h1235));
    idle_cyc(); check("hold_done", observed(), ZERO);

    // hold on the last micro-op keeps stall high
    cyc(1'b1, 1'b1, 8'h08, 16'h0100, 1'b0, 1'b0);
    check("hlast_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    check("hlast_held", observed(), ex(1,1,1,1,1,1,3'd3,16'h0100));
    idle_cyc(); check("hlast_go", observed(), ex(1,0,1,1,1,1,3'd3,16'h0100));
    idle_cyc(); check("hlast_done", observed(), ZERO);

    // zero register list is a no-op
    cyc(1'b1, 1'b1, 8'h00, 16'h0055, 1'b0, 1'b0);
    check("zero_start", observed(), ZERO);
    idle_cyc(); check("zero_after", observed(), ZERO);

    // flush mid-sequence, then a fresh start two cycles later
    cyc(1'b1, 1'b1, 8'h0F, 16'h0200, 1'b0, 1'b0);
    check("fl_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    idle_cyc(); check("fl_r0", observed(), ex(1,1,1,1,1,0,3'd0,16'h0200));
    cyc(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    check("fl_r1_flushed", observed(), ex(1,1,1,1,1,0,3'd1,16'h0201));
    idle_cyc(); check("fl_idle1", observed(), ZERO);
    idle_cyc(); check("fl_idle2", observed(), ZERO);
    cyc(1'b1, 1'b0, 8'h06, 16'h0300, 1'b0, 1'b0);
    check("fl_restart", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    idle_cyc(); check("fl_new_r1", observed(), ex(1,1,1,0,0,0,3'd1,16'h0300));
    idle_cyc(); check("fl_new_r2", observed(), ex(1,0,1,0,0,1,3'd2,16'h0301));
    idle_cyc(); check("fl_new_done", observed(), ZERO);

    // flush together with start in IDLE: start ignored
    cyc(1'b1, 1'b1, 8'h03, 16'h0700, 1'b0, 1'b1);
    check("flst_same", observed(), ZERO);
    idle_cyc(); check("flst_after", observed(), ZERO);

    // asynchronous reset mid-SM
    cyc(1'b1, 1'b0, 8'h0F, 16'h0400, 1'b0, 1'b0);
    check("rst_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    idle_cyc(); check("rst_r0", observed(), ex(1,1,1,0,0,0,3'd0,16'h0400));
    #1 rst_n = 1'b0;
    #1 check("rst_async", observed(), ZERO);
    idle_cyc(); check("rst_held", observed(), ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc(); check("rst_post", observed(), ZERO);
    cyc(1'b1, 1'b1, 8'h02, 16'h0500, 1'b0, 1'b0);
    check("rst_new_start", observed(), ex(0,1,0,0,0,0,3'd0,16'h0000));
    idle_cyc(); check("rst_new_r1", observed(), ex(1,0,1,1,1,1,3'd1,16'h0500));
    idle_cyc(); check("rst_new_done", observed(), ZERO);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
